addsum_rdout: RTL and testbench
===============================

# addsum_rdout

Read-out engine for the accumulated partial-sum RAM. Once accumulation of an output tile is finished, this block walks sum-RAM addresses 0..I_len-1 through the RAM read port and absorbs the RAM read latency. It delivers each word once, in address order, on a valid/ready stream toward the output buffer/AXI write path. A small internal FIFO holds in-flight reads, so back-pressure never loses or duplicates a word.

## Interface
Parameters:
- C_DSIZE, 32, sum word width
- C_ASIZE, 10, sum-RAM address width
- C_LENSIZE, 9, width of I_len; requires C_LENSIZE <= C_ASIZE+1
- C_RD_LAT, 2, sum-RAM read latency from O_rd/O_raddr to I_rdata; legal values 1..3
- C_FDEPTH, 4, internal FIFO depth; requires C_FDEPTH >= C_RD_LAT+1

Ports:
- I_clk  in  1  single clock for the whole block
- I_rst_n  in  1  reset, asynchronous, active-low
- I_start  in  1  one-cycle start pulse; ignored while O_busy=1
- I_len  in  C_LENSIZE  number of words to read; sampled on an accepted I_start
- O_busy  out  1  high from the cycle after an accepted start until O_done
- O_done  out  1  one-cycle pulse at the end of a transfer
- O_rd  out  1  sum-RAM read strobe
- O_raddr  out  C_ASIZE  sum-RAM read address
- I_rdata  in  C_DSIZE  sum-RAM read data, valid C_RD_LAT cycles after O_rd
- O_tdata  out  C_DSIZE  stream data
- O_tvalid  out  1  stream valid
- O_tlast  out  1  marks the word read from address I_len-1
- I_tready  in  1  stream ready from downstream

## Operation
- States:
  - IDLE: waits for I_start.
  - READ: issues reads.
  - DRAIN: all reads issued; waits for the FIFO and pipeline to empty.
  - DONE: pulses O_done for one cycle, then returns to IDLE.
- Transitions:
  - IDLE -> READ on I_start with I_len != 0.
  - IDLE -> DONE on I_start with I_len == 0. No read is issued and no beat is produced.
  - READ -> DRAIN in the cycle after the read of address I_len-1 is issued.
  - DRAIN -> DONE in the cycle after the beat with O_tlast is accepted (O_tvalid & I_tready).
- Read issue: O_rd=1 in a READ cycle only if (reads in flight + FIFO occupancy) < C_FDEPTH. Read issue depends on that credit, not on I_tready directly.
- Addresses: O_raddr starts at 0 and increments by 1 per issued read. The address counter is C_ASIZE wide and wraps modulo 2^C_ASIZE. O_raddr holds its last value when O_rd=0.
- Read tracking: a C_RD_LAT-deep shift register of read strobes, carrying a last flag, marks which cycles of I_rdata are captured into the FIFO along with the tlast bit.
- Output stream:
  - O_tdata, O_tvalid and O_tlast are registered from the FIFO head.
  - Once O_tvalid is high, O_tdata and O_tlast stay stable until the beat is accepted.
  - Exactly I_len beats are produced, in ascending address order.
- Start handling: an I_start pulse while O_busy=1 is ignored, has no side effects, and the running transfer continues.
- Word count: an internal remaining-count register of C_LENSIZE bits. I_len is used as given, with no clamp.

## Timing
- Reset values:
  - O_busy=0, O_done=0, O_rd=0, O_raddr=0, O_tvalid=0, O_tlast=0, O_tdata=0.
  - FIFO empty, state IDLE.
- Reset mid-operation: async assertion clears all state immediately. In-flight RAM data arriving after reset release is discarded. No beat is emitted until the next I_start.
- Cycle numbering: start accepted at edge 0; O_busy=1 and the first O_rd (address 0) occur in cycle 1.
- Latency: I_rdata for a read issued in cycle n is captured at the end of cycle n+C_RD_LAT. The first O_tvalid is in cycle C_RD_LAT+2.
- Throughput: with I_tready held high, one read and one beat per cycle. The last beat is in cycle I_len+C_RD_LAT+1, and O_done is in the cycle after it.
- Back-pressure: I_tready=0 stops reads within the credit limit. At most C_FDEPTH words are ever buffered, and none are dropped.
- Zero length: I_len=0 gives O_busy=1 in cycle 1, O_done in cycle 2, then IDLE.
- Restart: a new I_start is accepted in the cycle O_done is high? No — it is accepted only once back in IDLE, i.e. the cycle after O_done.

## Test plan
- RAM preloaded with data[a] = a+100; I_len=4; I_tready=1 -> beats 100,101,102,103 in cycles 4..7 (C_RD_LAT=2); O_tlast only on 103; O_done in cycle 8.
- I_len=300 with I_tready toggled randomly (50%) -> exactly 300 beats in order, none duplicated or dropped; FIFO occupancy never exceeds 4; O_tdata stable while stalled.
- I_len=0 -> no O_rd, no O_tvalid; O_done pulse in cycle 2.
- I_len=1 -> single beat, data[0], with O_tlast=1; then O_done.
- I_start pulsed mid-transfer with a different I_len -> ignored; the original count completes.
- I_rst_n asserted with 3 words in flight, then released -> all outputs return to 0 and stay idle; a new start with I_len=2 yields data[0], data[1] only.

Source files
------------

// File: rtl/addsum_rdout_if.sv
// addsum_rdout_if: valid/ready word stream from the sum-RAM read-out engine
// toward the output buffer / AXI write path.
//   tdata  : C_DSIZE-bit stream word
//   tvalid : word valid
//   tlast  : final word of the transfer
//   tready : downstream ready
// master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface addsum_rdout_if #(
  parameter int C_DSIZE = 32
);
  logic [C_DSIZE-1:0] tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/addsum_rdout.sv
// addsum_rdout: walks sum-RAM addresses 0..I_len-1, absorbs the RAM read
// latency and delivers each word once, in address order, on a valid/ready
// stream. Reads are issued only while the in-flight reads plus buffered
// words fit in the internal FIFO, so back-pressure never drops a word.
// Ports:
//   I_clk, I_rst_n : clock, asynchronous active-low reset
//   I_start, I_len : start pulse and word count (sampled when idle)
//   O_busy, O_done : transfer in progress / one-cycle completion pulse
//   O_rd, O_raddr  : sum-RAM read strobe and address
//   I_rdata        : sum-RAM read data, C_RD_LAT cycles after O_rd
//   m_axis         : output stream (tdata/tvalid/tlast out, tready in)
module addsum_rdout #(
  parameter int C_DSIZE   = 32,
  parameter int C_ASIZE   = 10,
  parameter int C_LENSIZE = 9,
  parameter int C_RD_LAT  = 2,
  parameter int C_FDEPTH  = 4
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_start,
  input  logic [C_LENSIZE-1:0] I_len,
  output logic                 O_busy,
  output logic                 O_done,
  output logic                 O_rd,
  output logic [C_ASIZE-1:0]   O_raddr,
  input  logic [C_DSIZE-1:0]   I_rdata,
  addsum_rdout_if.master       m_axis
);

  localparam int PW = (C_FDEPTH > 1) ? $clog2(C_FDEPTH) : 1;
  localparam int CW = $clog2(C_FDEPTH + 1);
  localparam int OW = $clog2(C_FDEPTH + C_RD_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [C_LENSIZE-1:0] rd_left_q;
  logic                 zlen_q;
  logic [C_ASIZE-1:0]   addr_q, hold_q;
  logic [C_RD_LAT-1:0]  vld_q, lst_q;
  logic [C_DSIZE:0]     mem [C_FDEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        cnt_q;
  logic [C_DSIZE-1:0]   tdata_q;
  logic                 tvalid_q, tlast_q;

  logic                 start_acc, credit_ok, cap, cap_last;
  logic                 out_free, fifo_empty, push, pop, beat_last;
  logic [OW-1:0]        occ;

  assign start_acc  = (state_q == S_IDLE) && I_start;
  assign cap        = vld_q[C_RD_LAT-1];
  assign cap_last   = lst_q[C_RD_LAT-1];
  assign out_free   = !tvalid_q || m_axis.tready;
  assign fifo_empty = (cnt_q == '0);
  assign pop        = out_free && !fifo_empty;
  // A captured word bypasses the FIFO only when the output register is free
  // and nothing older is waiting.
  assign push       = cap && !(out_free && fifo_empty);
  assign beat_last  = tvalid_q && m_axis.tready && tlast_q;

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;

  // Words committed to this block: in flight in the RAM plus buffered
  // (FIFO entries and the output register).
  always_comb begin
    occ = OW'(cnt_q) + OW'(tvalid_q);
    for (int unsigned i = 0; i < C_RD_LAT; i++) begin
      occ = occ + OW'(vld_q[i]);
    end
    credit_ok = (occ < OW'(C_FDEPTH));
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(C_FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_start) state_d = (I_len == '0) ? S_DONE : S_READ;
      S_READ:  if (O_rd && (rd_left_q == C_LENSIZE'(1))) state_d = S_DRAIN;
      S_DRAIN: if (beat_last) state_d = S_DONE;
      // A zero-length transfer spends one extra cycle here so its O_done
      // lands one cycle after O_busy rises.
      S_DONE:  state_d = zlen_q ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    O_busy  = (state_q != S_IDLE);
    O_done  = (state_q == S_DONE) && !zlen_q;
    O_rd    = (state_q == S_READ) && credit_ok && (rd_left_q != '0);
    O_raddr = O_rd ? addr_q : hold_q;
  end

  // Read issue, read-latency tracking and output register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd_left_q <= '0;
      zlen_q    <= 1'b0;
      addr_q    <= '0;
      hold_q    <= '0;
      vld_q     <= '0;
      lst_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      if (start_acc) begin
        rd_left_q <= I_len;
        addr_q    <= '0;
        zlen_q    <= (I_len == '0);
      end else begin
        if (O_rd) begin
          rd_left_q <= rd_left_q - 1'b1;
          addr_q    <= addr_q + 1'b1;
          hold_q    <= addr_q;
        end
        if (state_q == S_DONE) zlen_q <= 1'b0;
      end

      vld_q[0] <= O_rd;
      lst_q[0] <= O_rd && (rd_left_q == C_LENSIZE'(1));
      for (int unsigned i = 1; i < C_RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end

      if (out_free) begin
        if (!fifo_empty) begin
          {tlast_q, tdata_q} <= mem[rptr_q];
          tvalid_q           <= 1'b1;
        end else if (cap) begin
          {tlast_q, tdata_q} <= {cap_last, I_rdata};
          tvalid_q           <= 1'b1;
        end else begin
          tvalid_q <= 1'b0;
        end
      end

      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge I_clk) begin
    if (push) mem[wptr_q] <= {cap_last, I_rdata};
  end

endmodule

// File: tb/tb_addsum_rdout.sv
module tb_addsum_rdout;
  localparam int DS  = 32;
  localparam int AS  = 10;
  localparam int LS  = 9;
  localparam int LAT = 2;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          I_start;
  logic [LS-1:0] I_len;
  logic          O_busy, O_done, O_rd;
  logic [AS-1:0] O_raddr;
  logic [DS-1:0] I_rdata;
  logic          tready = 1'b0;

  always #5 clk = ~clk;

  addsum_rdout_if #(.C_DSIZE(DS)) axis ();
  assign axis.tready = tready;

  addsum_rdout #(
    .C_DSIZE(DS), .C_ASIZE(AS), .C_LENSIZE(LS), .C_RD_LAT(LAT), .C_FDEPTH(FD)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(I_start), .I_len(I_len),
    .O_busy(O_busy), .O_done(O_done), .O_rd(O_rd), .O_raddr(O_raddr),
    .I_rdata(I_rdata), .m_axis(axis)
  );

  // Sum RAM: data[a] = a + 100, LAT-cycle read pipeline.
  logic [DS-1:0] rp [LAT];
  always @(posedge clk) begin
    rp[0] <= DS'(O_raddr) + 100;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign I_rdata = rp[LAT-1];

  int checks = 0, passes = 0;
  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask
  task automatic check_le(input string nm, input longint got, input longint lim);
    checks++;
    if (got <= lim) passes++;
    else $display("FAIL %s: got %0d expected at most %0d", nm, got, lim);
  endtask

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // Transfer model: one transfer of L words yields data[0..L-1] in order,
  // tlast on the final word; with tready held high beat k is in cycle
  // k+LAT+2 and O_done in cycle L+LAT+2 (cycle 2 for L=0).
  bit      active = 1'b0, timed = 1'b0, held = 1'b0;
  int      L = 0, E = 0, beat_idx = 0, rd_idx = 0, first_cyc, done_cyc, cyc;
  logic [DS-1:0] hd;
  logic    hl;
  int      log_data[$];
  bit      log_last[$];
  int      rmode = 0;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       tready = 1'b1;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", O_busy, 0);
      check("rst_done", O_done, 0);
      check("rst_rd", O_rd, 0);
      check("rst_raddr", O_raddr, 0);
      check("rst_tvalid", axis.tvalid, 0);
      check("rst_tlast", axis.tlast, 0);
      check("rst_tdata", axis.tdata, 0);
      held = 1'b0;
    end else begin
      cyc = cnt - E + 1;
      check("busy", O_busy, active);
      if (O_rd) begin
        check("rd_in_xfer", (active && rd_idx < L), 1);
        check("raddr", O_raddr, rd_idx % (1 << AS));
        rd_idx++;
      end
      if (axis.tvalid) begin
        check("tvalid_in_xfer", active, 1);
        if (held) begin
          check("hold_data", axis.tdata, hd);
          check("hold_last", axis.tlast, hl);
        end
        if (tready) begin
          check("beat_data", axis.tdata, 100 + beat_idx);
          check("beat_last", axis.tlast, (beat_idx == L - 1));
          if (timed) check("beat_cycle", cyc, beat_idx + LAT + 2);
          if (beat_idx == 0) first_cyc = cyc;
          log_data.push_back(int'(axis.tdata));
          log_last.push_back(axis.tlast);
          beat_idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = axis.tdata;
          hl   = axis.tlast;
        end
      end else if (held) begin
        check("tvalid_dropped", 0, 1);
        held = 1'b0;
      end
      check_le("occupancy", rd_idx - beat_idx, FD);
      if (O_done) begin
        check("done_in_xfer", active, 1);
        check("done_beats", beat_idx, L);
        check("done_reads", rd_idx, L);
        if (timed) check("done_cycle", cyc, (L == 0) ? 2 : L + LAT + 2);
        done_cyc = cyc;
        active   = 1'b0;
      end
    end
  end

  task automatic start_xfer(input int len, input bit tm);
    @(posedge clk); #1;
    I_start = 1'b1;
    I_len   = LS'(len);
    @(posedge clk); #1;
    I_start = 1'b0;
    E = cnt; L = len; beat_idx = 0; rd_idx = 0; timed = tm;
    first_cyc = -1; done_cyc = -1;
    log_data.delete(); log_last.delete();
    active = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!active) break;
    end
    check("xfer_completes", active, 0);
  endtask

  initial begin
    rst_n = 1'b0; I_start = 1'b0; I_len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Four words, tready high
    start_xfer(4, 1); wait_idle(100);
    check("t4_count", log_data.size(), 4);
    if (log_data.size() == 4) begin
      check("t4_w0", log_data[0], 100);
      check("t4_w1", log_data[1], 101);
      check("t4_w2", log_data[2], 102);
      check("t4_w3", log_data[3], 103);
      check("t4_last0", log_last[0], 0);
      check("t4_last3", log_last[3], 1);
    end
    check("t4_first_cycle", first_cyc, 4);
    check("t4_done_cycle", done_cyc, 8);

    // Zero length
    start_xfer(0, 1); wait_idle(20);
    check("t0_count", log_data.size(), 0);
    check("t0_done_cycle", done_cyc, 2);

    // Single word
    start_xfer(1, 1); wait_idle(50);
    check("t1_count", log_data.size(), 1);
    if (log_data.size() == 1) begin
      check("t1_w0", log_data[0], 100);
      check("t1_last", log_last[0], 1);
    end
    check("t1_done_cycle", done_cyc, 5);

    // Start pulse with a different length mid-transfer is ignored
    start_xfer(20, 1);
    repeat (5) @(posedge clk);
    #1 I_start = 1'b1; I_len = LS'(5);
    @(posedge clk); #1 I_start = 1'b0;
    wait_idle(200);
    check("t20_count", log_data.size(), 20);
    if (log_data.size() == 20) check("t20_w19", log_data[19], 119);
    check("t20_done_cycle", done_cyc, 24);

    // Long transfer under random back-pressure
    rmode = 1;
    start_xfer(300, 0); wait_idle(3000);
    check("t300_count", log_data.size(), 300);
    if (log_data.size() == 300) check("t300_w299", log_data[299], 399);
    rmode = 0;

    // Reset with reads in flight, then a fresh short transfer
    rmode = 2;
    start_xfer(10, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; active = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rmode = 0;
    repeat (10) @(posedge clk);
    check("rst_no_beats", log_data.size(), 0);
    start_xfer(2, 1); wait_idle(50);
    check("t2_count", log_data.size(), 2);
    if (log_data.size() == 2) begin
      check("t2_w0", log_data[0], 100);
      check("t2_w1", log_data[1], 101);
    end
    check("t2_done_cycle", done_cyc, 6);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
